// File: rtl/game_state_ctrl.sv
// Game sequencer: debounced start/pause, IDLE/PLAY/PAUSE/OVER FSM, high score, play timer, flash.
// Optional macro GAME_PAUSE_EN builds the pause debouncer and the PAUSE state.
module game_state_ctrl #(
  parameter int unsigned DEBOUNCE_MS  = 20,
  parameter int unsigned OVER_HOLD_MS = 2000,
  parameter int unsigned FLASH_MS     = 250,
  parameter int unsigned MAX_SECONDS  = 999
) (
  input  logic       clk_1ms,
  input  logic       reset,
  input  logic       start_btn,
  input  logic       pause_btn,
  input  logic [5:0] game_over_in,
  input  logic [5:0] score_in,
  output logic [1:0] game_state,
  output logic       round_reset_n,
  output logic [5:0] high_score,
  output logic [9:0] play_seconds,
  output logic       over_flash
);

  localparam int unsigned DbW    = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS) : 1;
  localparam int unsigned HoldW  = (OVER_HOLD_MS > 1) ? $clog2(OVER_HOLD_MS) : 1;
  localparam int unsigned FlashW = (FLASH_MS > 1) ? $clog2(FLASH_MS) : 1;
  localparam logic [DbW-1:0]    DbLast    = DbW'(DEBOUNCE_MS - 1);
  localparam logic [HoldW-1:0]  HoldLast  = HoldW'(OVER_HOLD_MS - 1);
  localparam logic [FlashW-1:0] FlashLast = FlashW'(FLASH_MS - 1);
  localparam logic [9:0]        MsLast    = 10'd999;
  localparam logic [9:0]        MaxSecs   = 10'(MAX_SECONDS);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StPlay  = 2'b01,
    StPause = 2'b10,
    StOver  = 2'b11
  } state_e;

  state_e state_q, state_d;

  logic [DbW-1:0]    start_cnt_q, start_cnt_d;
  logic              start_lvl_q, start_lvl_d, start_press_q, start_press_d;
  logic              pause_press;
  logic [9:0]        ms_q, ms_d, secs_q, secs_d;
  logic [HoldW-1:0]  hold_q, hold_d;
  logic [FlashW-1:0] flash_cnt_q, flash_cnt_d;
  logic              flash_q, flash_d, rrn_q, rrn_d;
  logic [5:0]        high_q, high_d;

  // Accepted level flips after DEBOUNCE_MS consecutive differing samples; press is registered.
  always_comb begin
    start_cnt_d   = '0;
    start_lvl_d   = start_lvl_q;
    start_press_d = 1'b0;
    if (start_btn != start_lvl_q) begin
      if (start_cnt_q == DbLast) begin
        start_lvl_d   = start_btn;
        start_press_d = start_btn;
      end else begin
        start_cnt_d = start_cnt_q + DbW'(1);
      end
    end
  end

`ifdef GAME_PAUSE_EN
  logic [DbW-1:0] pause_cnt_q, pause_cnt_d;
  logic           pause_lvl_q, pause_lvl_d, pause_press_q, pause_press_d;

  always_comb begin
    pause_cnt_d   = '0;
    pause_lvl_d   = pause_lvl_q;
    pause_press_d = 1'b0;
    if (pause_btn != pause_lvl_q) begin
      if (pause_cnt_q == DbLast) begin
        pause_lvl_d   = pause_btn;
        pause_press_d = pause_btn;
      end else begin
        pause_cnt_d = pause_cnt_q + DbW'(1);
      end
    end
  end

  always_ff @(posedge clk_1ms) begin
    if (!reset) begin
      pause_cnt_q   <= '0;
      pause_lvl_q   <= 1'b0;
      pause_press_q <= 1'b0;
    end else begin
      pause_cnt_q   <= pause_cnt_d;
      pause_lvl_q   <= pause_lvl_d;
      pause_press_q <= pause_press_d;
    end
  end

  assign pause_press = pause_press_q;
`else
  logic unused_pause_btn;
  assign unused_pause_btn = pause_btn;
  assign pause_press      = 1'b0;
`endif

  always_ff @(posedge clk_1ms) begin
    if (!reset) begin
      state_q       <= StIdle;
      start_cnt_q   <= '0;
      start_lvl_q   <= 1'b0;
      start_press_q <= 1'b0;
      ms_q          <= '0;
      secs_q        <= '0;
      hold_q        <= '0;
      flash_cnt_q   <= '0;
      flash_q       <= 1'b0;
      rrn_q         <= 1'b1;
      high_q        <= '0;
    end else begin
      state_q       <= state_d;
      start_cnt_q   <= start_cnt_d;
      start_lvl_q   <= start_lvl_d;
      start_press_q <= start_press_d;
      ms_q          <= ms_d;
      secs_q        <= secs_d;
      hold_q        <= hold_d;
      flash_cnt_q   <= flash_cnt_d;
      flash_q       <= flash_d;
      rrn_q         <= rrn_d;
      high_q        <= high_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_press_q) state_d = StPlay;
      StPlay: begin
        if (game_over_in != 6'd0) state_d = StOver;
        else if (pause_press)     state_d = StPause;
      end
      StPause: if (pause_press) state_d = StPlay;
      StOver:  if (start_press_q && (hold_q >= HoldLast)) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ms_d        = ms_q;
    secs_d      = secs_q;
    hold_d      = hold_q;
    flash_cnt_d = '0;
    flash_d     = 1'b0;
    high_d      = high_q;
    rrn_d       = !(state_q == StOver && state_d == StIdle);

    if (state_q == StIdle && state_d == StPlay) begin
      ms_d   = '0;
      secs_d = '0;
    end else if (state_q == StPlay) begin
      if (ms_q == MsLast) begin
        ms_d = '0;
        if (secs_q != MaxSecs) secs_d = secs_q + 10'd1;
      end else begin
        ms_d = ms_q + 10'd1;
      end
    end

    if (state_q == StPlay && state_d == StOver && score_in > high_q) high_d = score_in;

    if (state_d == StOver && state_q != StOver) begin
      hold_d  = '0;
      flash_d = 1'b1;
    end else if (state_q == StOver && state_d == StOver) begin
      if (hold_q != HoldLast) hold_d = hold_q + HoldW'(1);
      if (flash_cnt_q == FlashLast) begin
        flash_d = ~flash_q;
      end else begin
        flash_d     = flash_q;
        flash_cnt_d = flash_cnt_q + FlashW'(1);
      end
    end
  end

  assign game_state    = state_q;
  assign round_reset_n = rrn_q;
  assign high_score    = high_q;
  assign play_seconds  = secs_q;
  assign over_flash    = flash_q;

endmodule
